vram_pixel_feeder: RTL and testbench
====================================

Name: vram_pixel_feeder

Overview:
- Upstream stage of the HDMI video timing block. Fetches one frame of H_ACTIVE x V_ACTIVE PSX 15-bit BGR555 pixels from VRAM, starting at a programmable framebuffer origin.
- Buffers the pixels in a credit-limited FIFO and expands each one to 36-bit RGB 12:12:12.
- Presents pixels on an en/rdy handshake that drives the video block's data/en inputs and receives its rdy output.

Parameters:
- H_ACTIVE, 720, active pixels per line
- V_ACTIVE, 480, active lines per frame
- FIFO_DEPTH, 16, pixel FIFO entries (power of 2, >=4)
- ADDR_W, 19, VRAM halfword address width (1024 x 512 VRAM)

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- enable  input  1  run continuous frames while high
- fb_base_x  input  10  framebuffer origin X, latched at frame start
- fb_base_y  input  9  framebuffer origin Y, latched at frame start
- vram_req  output  1  read request valid
- vram_addr  output  ADDR_W  read halfword address
- vram_gnt  input  1  request accepted this cycle (when vram_req high)
- vram_rvalid  input  1  read data valid; data returns in order, any latency >=1
- vram_rdata  input  16  read data: [4:0]=R, [9:5]=G, [14:10]=B, [15] ignored
- pix_data  output  36  [35:24]=R12, [23:12]=G12, [11:0]=B12
- pix_en  output  1  pix_data valid
- pix_rdy  input  1  consumer ready; a pixel transfers on pix_en && pix_rdy
- frame_start  output  1  high with pix_en on the first pixel of each frame
- busy  output  1  state != IDLE
- underflow  output  1  sticky; see below
- rd_err  output  1  sticky; vram_rvalid seen with zero outstanding requests

Behaviour:
- Reset values: vram_req=0, vram_addr=0, pix_en=0, pix_data=0, frame_start=0, busy=0, underflow=0, rd_err=0. FIFO is empty, all counters are 0, state is IDLE.
- States:
  - IDLE: when enable=1, latch fb_base_x/fb_base_y, clear x/y request counters and the output pixel counter, clear underflow and rd_err, then go to FETCH.
  - FETCH: issue requests. Every time a request is accepted at x=H_ACTIVE-1 and y=V_ACTIVE-1, go to DRAIN.
  - DRAIN: no requests are issued. Once the last pixel of the frame transfers (output count = H_ACTIVE*V_ACTIVE): if enable=1, re-latch the base, clear counters and go to FETCH on the next cycle; otherwise go to IDLE.
- Deasserting enable mid-frame does not truncate the frame. The current frame completes, then the block returns to IDLE.
- Address: vram_addr = {(base_y + y) mod 512, (base_x + x) mod 1024}. X and Y wrap independently, with no carry from X into Y.
- Request counters: on acceptance, x increments. At x=H_ACTIVE-1, x wraps to 0 and y increments.
- Credits:
  - vram_req = (state==FETCH) && (outstanding + fifo_count < FIFO_DEPTH).
  - outstanding is +1 on acceptance and -1 on vram_rvalid; both in the same cycle leaves it unchanged.
  - The FIFO can never overflow.
- vram_addr is held stable while vram_req=1 and vram_gnt=0.
- FIFO write: registered on vram_rvalid. The pixel is visible on pix_en the cycle after rvalid (1-cycle latency).
- FIFO read: show-ahead.
  - pix_en = FIFO not empty; pix_data is combinationally derived from the head entry.
  - Pop occurs on pix_en && pix_rdy.
  - Simultaneous push and pop leaves fifo_count unchanged and is legal even when the FIFO is full.
- Colour expansion: c12 = {c5, c5, c5[4:3]}. Examples: 0x1F -> 0xFFF, 0x00 -> 0x000, 0x10 -> 0x842.
- frame_start = pix_en && (output pixel count == 0).
- underflow is set when state is FETCH or DRAIN, the output count is between 1 and H_ACTIVE*V_ACTIVE-1, pix_rdy=1 and pix_en=0.
- rd_err: rvalid with outstanding=0 is ignored (no FIFO write) and sets rd_err.
- Reset mid-operation returns everything to reset values immediately; in-flight VRAM data arriving after reset sets rd_err.

Test Plan:
1. Reset, base=(0,0), enable=1, vram_gnt=1, rvalid 3 cycles after each grant, pix_rdy=1 -> first vram_addr=0; 345600 pixels delivered; frame_start exactly once per frame; underflow=0.
2. rdata 0x001F, 0x03E0, 0x7C00, 0x8210 -> pix_data 0xFFF000000, 0x000FFF000, 0x000000FFF, 0x842842000 (bit 15 ignored).
3. pix_rdy=0 with grants free -> exactly FIFO_DEPTH requests issued, then vram_req=0; raise pix_rdy -> requests resume; no data is lost and no overflow occurs.
4. Base=(1000,500) -> line 0 addresses go 500*1024+1000 ... 500*1024+1023, then 500*1024+0; line 12 uses row 0 (wrap to 0).
5. Deassert enable mid-frame -> frame still completes, busy falls after the last transfer, no new requests; with enable held, the next frame starts without a gap and latches new base values.
6. Stall vram_gnt mid-frame while pix_rdy=1 -> underflow sets and stays set until the next start from IDLE; rvalid pulse at idle -> rd_err=1 and the FIFO stays empty.

Source files
------------

// File: rtl/vram_pixel_feeder.sv
// Fetches one H_ACTIVE x V_ACTIVE frame of BGR555 pixels from VRAM and streams them out as
// RGB 12:12:12 through a credit-limited show-ahead FIFO on an en/rdy handshake.
module vram_pixel_feeder #(
  parameter int H_ACTIVE   = 720,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [9:0]        fb_base_x,
  input  logic [8:0]        fb_base_y,
  output logic              vram_req,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic              vram_gnt,
  input  logic              vram_rvalid,
  input  logic [15:0]       vram_rdata,
  output logic [35:0]       pix_data,
  output logic              pix_en,
  input  logic              pix_rdy,
  output logic              frame_start,
  output logic              busy,
  output logic              underflow,
  output logic              rd_err
);
  localparam int TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int XW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int OW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;

  localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
  localparam logic [OW-1:0] PIX_LAST = OW'(TOTAL - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]    state;
  logic [9:0]    base_x;
  logic [8:0]    base_y;
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic [OW-1:0] out_cnt;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [14:0]   fifo_mem [FIFO_DEPTH];

  logic          accept;
  logic          push;
  logic          pop;
  logic          last_pix;
  logic [9:0]    addr_x;
  logic [8:0]    addr_y;
  logic [14:0]   head;
  logic          unused_bits;

  function automatic logic [11:0] expand5(input logic [4:0] c);
    return {c, c, c[4:3]};
  endfunction

  // Credits cover both in-flight reads and buffered pixels, so a granted read always has a slot.
  assign vram_req = (state == FETCH) && ((outstanding + fifo_count) < CW'(FIFO_DEPTH));
  assign accept   = vram_req && vram_gnt;
  assign push     = vram_rvalid && (outstanding != '0);
  assign pop      = pix_en && pix_rdy;
  assign last_pix = pop && (out_cnt == PIX_LAST);

  // X and Y wrap independently inside the 1024 x 512 VRAM.
  assign addr_x    = base_x + 10'(x_cnt);
  assign addr_y    = base_y + 9'(y_cnt);
  assign vram_addr = ADDR_W'({addr_y, addr_x});

  assign busy        = (state != IDLE);
  assign pix_en      = (fifo_count != '0);
  assign head        = fifo_mem[rd_ptr];
  assign pix_data    = pix_en ? {expand5(head[4:0]), expand5(head[9:5]), expand5(head[14:10])} : '0;
  assign frame_start = pix_en && (out_cnt == '0);
  assign unused_bits = vram_rdata[15];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= vram_rdata[14:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      base_x      <= '0;
      base_y      <= '0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      out_cnt     <= '0;
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      underflow   <= 1'b0;
      rd_err      <= 1'b0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(push);
      fifo_count  <= fifo_count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + PW'(1);
        out_cnt <= out_cnt + OW'(1);
      end

      case (state)
        IDLE: begin
          if (enable) begin
            base_x    <= fb_base_x;
            base_y    <= fb_base_y;
            x_cnt     <= '0;
            y_cnt     <= '0;
            out_cnt   <= '0;
            underflow <= 1'b0;
            rd_err    <= 1'b0;
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (accept) begin
            if (x_cnt == X_LAST) begin
              x_cnt <= '0;
              y_cnt <= y_cnt + YW'(1);
              if (y_cnt == Y_LAST) state <= DRAIN;
            end else begin
              x_cnt <= x_cnt + XW'(1);
            end
          end
        end
        DRAIN: begin
          if (last_pix) begin
            out_cnt <= '0;
            if (enable) begin
              base_x <= fb_base_x;
              base_y <= fb_base_y;
              x_cnt  <= '0;
              y_cnt  <= '0;
              state  <= FETCH;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Sticky flags are evaluated last so a same-cycle event wins over the start-of-frame clear.
      if (vram_rvalid && (outstanding == '0)) rd_err <= 1'b1;
      if ((state != IDLE) && (out_cnt != '0) && pix_rdy && !pix_en) underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vram_pixel_feeder.sv
// Directed bench for vram_pixel_feeder: a fixed-latency VRAM responder, a pixel scoreboard
// and a colour-expansion vector table, run on a reduced 32 x 16 frame.
module tb_vram_pixel_feeder;
  localparam int H     = 32;
  localparam int V     = 16;
  localparam int DEPTH = 16;
  localparam int TOTAL = H * V;
  localparam int NV    = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [9:0]  fb_base_x;
  logic [8:0]  fb_base_y;
  logic        vram_req;
  logic [18:0] vram_addr;
  logic        vram_gnt;
  logic        vram_rvalid;
  logic [15:0] vram_rdata;
  logic [35:0] pix_data;
  logic        pix_en;
  logic        pix_rdy;
  logic        frame_start;
  logic        busy;
  logic        underflow;
  logic        rd_err;

  vram_pixel_feeder #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(DEPTH), .ADDR_W(19)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fb_base_x(fb_base_x), .fb_base_y(fb_base_y),
    .vram_req(vram_req), .vram_addr(vram_addr), .vram_gnt(vram_gnt),
    .vram_rvalid(vram_rvalid), .vram_rdata(vram_rdata), .pix_data(pix_data),
    .pix_en(pix_en), .pix_rdy(pix_rdy), .frame_start(frame_start), .busy(busy),
    .underflow(underflow), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rdata;
    logic [35:0] pix;
  } colour_vec_t;

  colour_vec_t tv [NV];

  int checks = 0;
  int errors = 0;

  bit gnt_en = 1'b1;
  bit rdy_en = 1'b1;
  bit tbl_mode = 1'b0;
  bit inject = 1'b0;
  bit cap_en = 1'b0;
  bit mon_en = 1'b0;

  int ex = 0, ey = 0, cbx = 0, cby = 0, nbx = 0, nby = 0;
  int acc_cnt = 0, tbl_idx = 0, gap_cnt = 0;
  int out_i = 0, pix_total = 0, fs_cnt = 0;
  int acc_log[$];
  logic [15:0] exp_q[$];
  logic [35:0] cap [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  function automatic logic [35:0] exp_pix(input logic [15:0] w);
    logic [4:0] r, g, b;
    r = w[4:0];
    g = w[9:5];
    b = w[14:10];
    return {r, r, r[4:3], g, g, g[4:3], b, b, b[4:3]};
  endfunction

  function automatic int log_at(input int i);
    return (i < acc_log.size()) ? acc_log[i] : -1;
  endfunction

  // VRAM responder: grant per gnt_en, data returns 3 cycles after each grant.
  initial begin
    logic        pv [3];
    logic [15:0] pd [3];
    int          ea;
    logic [15:0] w;
    vram_gnt = 1'b0;
    vram_rvalid = 1'b0;
    vram_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
    forever begin
      @(negedge clk);
      vram_gnt = gnt_en;
      vram_rvalid = pv[2];
      vram_rdata = pd[2];
      if (pv[2]) exp_q.push_back(pd[2]);
      if (inject) begin
        vram_rvalid = 1'b1;
        vram_rdata = 16'h7FFF;
        inject = 1'b0;
      end
      pv[2] = pv[1]; pd[2] = pd[1];
      pv[1] = pv[0]; pd[1] = pd[0];
      pv[0] = 1'b0;
      if (vram_req && vram_gnt) begin
        ea = ((cby + ey) % 512) * 1024 + ((cbx + ex) % 1024);
        chk("req addr", vram_addr, ea);
        acc_log.push_back(int'(vram_addr));
        acc_cnt++;
        if (tbl_mode && tbl_idx < NV) begin
          w = tv[tbl_idx].rdata;
          tbl_idx++;
        end else begin
          w = 16'((ea * 37) ^ 16'h9C3B);
        end
        pv[0] = 1'b1;
        pd[0] = w;
        ex++;
        if (ex == H) begin
          ex = 0;
          ey++;
          if (ey == V) begin
            ey = 0;
            cbx = nbx;
            cby = nby;
          end
        end
      end
    end
  end

  // Pixel consumer and scoreboard.
  initial begin
    logic [15:0] w;
    pix_rdy = 1'b0;
    forever begin
      @(negedge clk);
      pix_rdy = rdy_en;
      if (pix_en && pix_rdy) begin
        chk("frame_start", frame_start, out_i == 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious pixel: got %0h, want none", pix_data);
        end else begin
          w = exp_q.pop_front();
          chk("pix_data", pix_data, exp_pix(w));
        end
        if (cap_en && out_i < NV) cap[out_i] = pix_data;
        if (frame_start) fs_cnt++;
        out_i = (out_i + 1) % TOTAL;
        pix_total++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !busy) gap_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic start_frame(input int bx, input int by);
    fb_base_x = 10'(bx);
    fb_base_y = 9'(by);
    cbx = bx; cby = by; nbx = bx; nby = by;
    pix_total = 0; fs_cnt = 0; acc_cnt = 0;
    acc_log.delete();
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_busy(input string nm);
    int n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " start"}, busy, 1);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " done"}, busy, 0);
  endtask

  initial begin
    int n;
    int a;
    tv[0] = '{16'h001F, 36'hFFF000000};
    tv[1] = '{16'h03E0, 36'h000FFF000};
    tv[2] = '{16'h7C00, 36'h000000FFF};
    tv[3] = '{16'h8210, 36'h842842000};
    tv[4] = '{16'h0000, 36'h000000000};
    tv[5] = '{16'h7FFF, 36'hFFFFFFFFF};
    tv[6] = '{16'hFFFF, 36'hFFFFFFFFF};
    tv[7] = '{16'h0421, 36'h084084084};
    tv[8] = '{16'h5555, 36'hAD6529AD6};

    rst = 1'b1;
    enable = 1'b0;
    fb_base_x = '0;
    fb_base_y = '0;
    repeat (3) @(negedge clk);
    chk("reset vram_req", vram_req, 0);
    chk("reset vram_addr", vram_addr, 0);
    chk("reset pix_en", pix_en, 0);
    chk("reset pix_data", pix_data, 0);
    chk("reset frame_start", frame_start, 0);
    chk("reset busy", busy, 0);
    chk("reset underflow", underflow, 0);
    chk("reset rd_err", rd_err, 0);
    $display("reset: outputs sampled");
    rst = 1'b0;
    @(negedge clk);

    // Single frame at base (0,0) with the colour table driving the first pixels.
    tbl_mode = 1'b1; tbl_idx = 0; cap_en = 1'b1;
    start_frame(0, 0);
    wait_busy("t1");
    enable = 1'b0;
    wait_idle("t1", 3000);
    chk("t1 first addr", log_at(0), 0);
    chk("t1 pixels", pix_total, TOTAL);
    chk("t1 frame_start count", fs_cnt, 1);
    chk("t1 underflow", underflow, 0);
    chk("t1 rd_err", rd_err, 0);
    chk("t1 scoreboard empty", exp_q.size(), 0);
    $display("t1: frame delivered %0d pixels", pix_total);
    for (int i = 0; i < NV; i++) begin
      chk("colour", cap[i], tv[i].pix);
      $display("colour %0d: rdata=%h pix=%h", i, tv[i].rdata, cap[i]);
    end
    tbl_mode = 1'b0; cap_en = 1'b0;

    // Consumer stalled: credits must stop requests at exactly FIFO_DEPTH.
    rdy_en = 1'b0;
    start_frame(3, 2);
    wait_busy("t3");
    enable = 1'b0;
    repeat (40) @(negedge clk);
    chk("t3 accepts while stalled", acc_cnt, DEPTH);
    chk("t3 vram_req", vram_req, 0);
    chk("t3 pix_en", pix_en, 1);
    chk("t3 frame_start held", frame_start, 1);
    rdy_en = 1'b1;
    wait_idle("t3", 3000);
    chk("t3 pixels", pix_total, TOTAL);
    chk("t3 frame_start count", fs_cnt, 1);
    chk("t3 underflow", underflow, 0);
    chk("t3 scoreboard empty", exp_q.size(), 0);
    $display("t3: stalled frame delivered %0d pixels", pix_total);

    // Origin near the VRAM corner: X and Y wrap independently.
    start_frame(1000, 500);
    wait_busy("t4");
    enable = 1'b0;
    wait_idle("t4", 3000);
    chk("t4 accepts", acc_log.size(), TOTAL);
    chk("t4 line0 x0", log_at(0), 513000);
    chk("t4 line0 x23", log_at(23), 513023);
    chk("t4 line0 x24 wrap", log_at(24), 512000);
    chk("t4 line0 x31", log_at(31), 512007);
    chk("t4 line11 x31", log_at(383), 523271);
    chk("t4 line12 row0", log_at(384), 1000);
    $display("t4: wrapped frame delivered %0d pixels", pix_total);

    // Back-to-back frames with a base change, then stop after the second.
    gap_cnt = 0;
    start_frame(10, 20);
    wait_busy("t5");
    mon_en = 1'b1;
    repeat (100) @(negedge clk);
    fb_base_x = 10'd200;
    fb_base_y = 9'd100;
    nbx = 200; nby = 100;
    n = 0;
    while (fs_cnt < 2 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("t5 second frame_start", fs_cnt, 2);
    enable = 1'b0;
    mon_en = 1'b0;
    wait_idle("t5", 3000);
    chk("t5 idle gap", gap_cnt, 0);
    chk("t5 pixels", pix_total, 2 * TOTAL);
    chk("t5 accepts", acc_log.size(), 2 * TOTAL);
    chk("t5 frame A first addr", log_at(0), 20490);
    chk("t5 frame B first addr", log_at(TOTAL), 102600);
    a = acc_cnt;
    repeat (20) @(negedge clk);
    chk("t5 no requests after idle", acc_cnt, a);
    chk("t5 vram_req", vram_req, 0);
    $display("t5: two frames delivered %0d pixels", pix_total);

    // Grant stall with a ready consumer raises the sticky underflow flag.
    start_frame(0, 0);
    wait_busy("t6");
    enable = 1'b0;
    n = 0;
    while (pix_total < 100 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("t6 reached 100 pixels", pix_total >= 100, 1);
    gnt_en = 1'b0;
    repeat (30) @(negedge clk);
    chk("t6 fifo empty in stall", pix_en, 0);
    chk("t6 underflow set", underflow, 1);
    gnt_en = 1'b1;
    wait_idle("t6", 3000);
    chk("t6 pixels", pix_total, TOTAL);
    chk("t6 underflow sticky", underflow, 1);
    inject = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6 rd_err", rd_err, 1);
    chk("t6 fifo stays empty", pix_en, 0);
    chk("t6 busy", busy, 0);
    start_frame(0, 0);
    wait_busy("t6 restart");
    chk("t6 underflow cleared", underflow, 0);
    chk("t6 rd_err cleared", rd_err, 0);
    enable = 1'b0;
    wait_idle("t6 restart", 3000);
    chk("t6 restart pixels", pix_total, TOTAL);
    $display("t6: underflow and rd_err exercised");

    // Reset in the middle of a frame; returning in-flight data flags rd_err.
    start_frame(0, 0);
    wait_busy("t7");
    repeat (50) @(negedge clk);
    enable = 1'b0;
    rst = 1'b1;
    #1;
    chk("t7 busy in reset", busy, 0);
    chk("t7 vram_req in reset", vram_req, 0);
    chk("t7 pix_en in reset", pix_en, 0);
    chk("t7 pix_data in reset", pix_data, 0);
    chk("t7 underflow in reset", underflow, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("t7 rd_err after reset", rd_err, 1);
    chk("t7 pix_en after reset", pix_en, 0);
    chk("t7 busy after reset", busy, 0);
    $display("t7: mid-frame reset done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
